// File: rtl/uart_rx_frame_check_pkg.sv
// Shared UART receive definitions: frame FSM states, parity mode encoding
// and the parity helper used by the frame checker.
package uart_rx_frame_check_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP1  = 3'd3,
        STOP2  = 3'd4
    } rx_state_t;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_t;

    // Value the parity bit must carry, given the XOR of all data bits.
    function automatic logic parity_expected(input logic data_xor, input parity_mode_t mode);
        return data_xor ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_frame_check_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module uart_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: deserialises LSB-first data, checks optional parity
// and one/two stop bits, and keeps saturating error counters.
module uart_rx_frame_check
    import uart_rx_frame_check_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  samp_valid,
    input  logic                  samp_data_in,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  two_stop,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_t             state;
    rx_state_t             state_next;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  cfg_par_en;
    logic                  cfg_two_stop;
    parity_mode_t          cfg_par_mode;
    logic                  frame_par_err;

    logic                  complete;
    logic                  par_mismatch;
    logic                  par_err_next;
    logic                  stop_err_next;
    logic                  par_inc;
    logic                  stop_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (frame_start) state_next = DATA;
            end
            DATA: begin
                if (samp_valid && (bit_cnt == LAST_BIT)) begin
                    state_next = cfg_par_en ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (samp_valid) state_next = STOP1;
            end
            STOP1: begin
                // A low first stop bit ends the frame even when two are configured.
                if (samp_valid) begin
                    state_next = (!samp_data_in || !cfg_two_stop) ? IDLE : STOP2;
                end
            end
            STOP2: begin
                if (samp_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        complete      = 1'b0;
        par_mismatch  = (samp_data_in != parity_expected(^shift_reg, cfg_par_mode));
        stop_err_next = ~samp_data_in;
        case (state)
            STOP1:   complete = samp_valid && (!samp_data_in || !cfg_two_stop);
            STOP2:   complete = samp_valid;
            default: complete = 1'b0;
        endcase
        par_err_next = cfg_par_en & frame_par_err;
        par_inc      = complete & par_err_next;
        stop_inc     = complete & stop_err_next;
    end

    // Data bits enter at the MSB and shift down, so the first bit lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            shift_reg     <= '0;
            cfg_par_en    <= 1'b0;
            cfg_two_stop  <= 1'b0;
            cfg_par_mode  <= PAR_EVEN;
            frame_par_err <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            par_err       <= 1'b0;
            stop_err      <= 1'b0;
        end else begin
            rx_valid <= complete;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        cfg_par_en    <= par_en;
                        cfg_two_stop  <= two_stop;
                        cfg_par_mode  <= parity_mode_t'(par_odd);
                        bit_cnt       <= '0;
                        frame_par_err <= 1'b0;
                    end
                end
                DATA: begin
                    if (samp_valid) begin
                        shift_reg <= {samp_data_in, shift_reg[DATA_WIDTH-1:1]};
                        bit_cnt   <= bit_cnt + BCW'(1);
                    end
                end
                PARITY: begin
                    if (samp_valid) frame_par_err <= par_mismatch;
                end
                default: ;
            endcase
            if (complete) begin
                rx_data  <= shift_reg;
                par_err  <= par_err_next;
                stop_err <= stop_err_next;
            end
        end
    end

    assign busy = (state != IDLE);

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (par_inc),
        .clr   (clr_cnt),
        .count (par_err_cnt)
    );

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stop_inc),
        .clr   (clr_cnt),
        .count (stop_err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench for uart_rx_frame_check: frames are modelled from the
// serial bit rules and compared whenever the DUT pulses rx_valid.
module tb_uart_rx_frame_check;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          samp_valid = 1'b0;
    logic          samp_data_in = 1'b0;
    logic          par_en = 1'b0;
    logic          par_odd = 1'b0;
    logic          two_stop = 1'b0;
    logic          clr_cnt = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          par_err;
    logic          stop_err;
    logic          busy;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stop_err_cnt;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          se;
        int            pc;
        int            sc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   m_par_cnt = 0;
    int   m_stop_cnt = 0;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .samp_valid   (samp_valid),
        .samp_data_in (samp_data_in),
        .par_en       (par_en),
        .par_odd      (par_odd),
        .two_stop     (two_stop),
        .clr_cnt      (clr_cnt),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .par_err      (par_err),
        .stop_err     (stop_err),
        .busy         (busy),
        .par_err_cnt  (par_err_cnt),
        .stop_err_cnt (stop_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Every rx_valid must match the oldest outstanding expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rx_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rx_data", 32'(rx_data), 32'(e.data));
                checkOutput("par_err", 32'(par_err), 32'(e.pe));
                checkOutput("stop_err", 32'(stop_err), 32'(e.se));
                checkOutput("par_err_cnt", 32'(par_err_cnt), e.pc);
                checkOutput("stop_err_cnt", 32'(stop_err_cnt), e.sc);
            end
        end
    end

    task automatic strobe(input bit b, input bit clr, input int max_gap);
        samp_valid   = 1'b1;
        samp_data_in = b;
        clr_cnt      = clr;
        @(posedge clk); #1;
        samp_valid   = 1'b0;
        clr_cnt      = 1'b0;
        samp_data_in = 1'($urandom_range(1, 0));
        repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input bit pen, input bit podd,
                                 input bit tstop, input bit pbit, input bit s1, input bit s2,
                                 input bit clr_last, input int max_gap);
        exp_t e;
        bit   last_is_s1;
        bit   data_odd;
        data_odd   = ($countones(data) % 2) == 1;
        e.data     = data;
        e.pe       = pen && (pbit != (data_odd ^ podd));
        e.se       = !s1 || (tstop && !s2);
        last_is_s1 = !s1 || !tstop;
        if (clr_last) begin
            m_par_cnt  = 0;
            m_stop_cnt = 0;
        end else begin
            if (e.pe && m_par_cnt < MAXC) m_par_cnt++;
            if (e.se && m_stop_cnt < MAXC) m_stop_cnt++;
        end
        e.pc = m_par_cnt;
        e.sc = m_stop_cnt;
        exp_q.push_back(e);

        par_en       = pen;
        par_odd      = podd;
        two_stop     = tstop;
        frame_start  = 1'b1;
        samp_valid   = 1'($urandom_range(1, 0));
        samp_data_in = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        frame_start  = 1'b0;
        samp_valid   = 1'b0;
        // Scramble config mid-frame; the latched copy must be used.
        par_en       = 1'($urandom_range(1, 0));
        par_odd      = 1'($urandom_range(1, 0));
        two_stop     = 1'($urandom_range(1, 0));
        for (int i = 0; i < DW; i++) strobe(data[i], 1'b0, max_gap);
        if (pen) strobe(pbit, 1'b0, max_gap);
        strobe(s1, clr_last && last_is_s1, max_gap);
        if (tstop) strobe(s2, clr_last && !last_is_s1, max_gap);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #3;
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_flags", {30'd0, par_err, stop_err}, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_counts", {16'd0, par_err_cnt, stop_err_cnt}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8'hA5, 0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("a5_latency", 32'(rx_valid), 32'd1);
        @(posedge clk); #1;
        checkOutput("a5_pulse_end", 32'(rx_valid), 32'd0);

        applyStimulus(8'h03, 1, 0, 0, 0, 1, 1, 0, 1);
        applyStimulus(8'h03, 1, 0, 0, 1, 1, 1, 0, 1);
        applyStimulus(8'h07, 1, 1, 0, 0, 1, 1, 0, 1);
        applyStimulus(8'h5A, 0, 0, 1, 0, 1, 0, 0, 1);
        applyStimulus(8'hC3, 0, 0, 1, 0, 0, 1, 0, 1);
        applyStimulus(8'h81, 1, 1, 1, 1, 1, 1, 0, 0);
        waitDrain();
        checkOutput("idle_after_stop0", 32'(busy), 32'd0);

        for (int k = 0; k < 40; k++) begin
            applyStimulus(8'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                          $urandom_range(7, 0) == 0, 2);
        end
        waitDrain();

        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt    = 1'b0;
        m_par_cnt  = 0;
        m_stop_cnt = 0;
        checkOutput("clr_counts", {16'd0, par_err_cnt, stop_err_cnt}, 32'd0);

        for (int k = 0; k < MAXC + 1; k++) begin
            applyStimulus(8'($urandom), 0, 0, 0, 0, 0, 1, 0, 0);
        end
        waitDrain();
        checkOutput("stop_cnt_saturated", 32'(stop_err_cnt), MAXC);
        applyStimulus(8'h11, 1, 0, 0, 1, 0, 1, 1, 0);
        waitDrain();
        checkOutput("clr_beats_inc", 32'(stop_err_cnt), 32'd0);

        applyStimulus(8'hFF, 1, 0, 0, 1, 0, 1, 0, 0);
        waitDrain();
        par_en      = 1'b0;
        two_stop    = 1'b0;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) strobe(1'($urandom_range(1, 0)), 1'b0, 0);
        checkOutput("busy_mid_frame", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rx_data", 32'(rx_data), 32'd0);
        checkOutput("abort_flags", {30'd0, par_err, stop_err}, 32'd0);
        checkOutput("abort_counts", {16'd0, par_err_cnt, stop_err_cnt}, 32'd0);
        m_par_cnt  = 0;
        m_stop_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'h3C, 0, 0, 0, 0, 1, 1, 0, 1);
        waitDrain();
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Sequential receive-side frame checker for the UART RX path, and the parametrised successor to the combinational stop-bit checker. It consumes one sampled bit per strobe from the RX sampler after the start bit is validated, and deserialises DATA_WIDTH data bits LSB-first. It checks optional even/odd parity and one or two stop bits, then presents the word with per-frame error flags and saturating error counters. It sits between the RX bit sampler and the RX FIFO/register interface.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- CNT_WIDTH, 8, width of each error counter.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- frame_start  in  1  one-cycle pulse from start-bit check: start bit accepted, frame begins.
- samp_valid  in  1  one-cycle strobe: samp_data_in holds the next frame bit.
- samp_data_in  in  1  sampled serial bit.
- par_en  in  1  1 = a parity bit follows the data bits.
- par_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  1 = two stop bits, 0 = one.
- clr_cnt  in  1  synchronous clear of both error counters.
- rx_data  out  DATA_WIDTH  last completed word.
- rx_valid  out  1  one-cycle pulse: rx_data, par_err and stop_err are updated.
- par_err  out  1  parity mismatch in the last frame.
- stop_err  out  1  a stop bit sampled 0 in the last frame.
- busy  out  1  frame in progress (state != IDLE).
- par_err_cnt  out  CNT_WIDTH  saturating count of frames with par_err.
- stop_err_cnt  out  CNT_WIDTH  saturating count of frames with stop_err.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE: on frame_start, latch par_en, par_odd and two_stop into frame-local registers, clear bit_cnt, go to DATA. Config changes mid-frame have no effect on the current frame.
- DATA:
  - Each samp_valid shifts samp_data_in into the shift register at bit bit_cnt (LSB first) and increments bit_cnt.
  - After DATA_WIDTH strobes, go to PARITY if latched par_en, else STOP1.
- PARITY: on samp_valid, expected = (XOR of data bits) XOR par_odd; par_err_next = (samp_data_in != expected). Go to STOP1.
- STOP1: on samp_valid, stop_err_next = !samp_data_in.
  - If samp_data_in = 0: complete the frame immediately, regardless of two_stop.
  - Else if two_stop: go to STOP2.
  - Else: complete.
- STOP2: on samp_valid, stop_err_next = !samp_data_in; complete.
- Completion: return to IDLE; update rx_data, par_err and stop_err; pulse rx_valid.
  - par_err is 0 when parity is disabled.
  - Outputs hold until the next completion.
- Counters: +1 on completion when the corresponding flag is set; saturate at all-ones.
- clr_cnt wins over a same-cycle increment, and the result is 0.
- frame_start outside IDLE is ignored. samp_valid in IDLE is ignored.
- busy = state != IDLE.
- Reset: state IDLE, bit_cnt 0; rx_data, rx_valid, par_err, stop_err and both counters 0; busy 0.

## Timing
- All outputs are registered.
- rx_valid asserts the cycle after the clock edge that samples the final frame bit, for exactly one cycle.
- rx_data and the flags change in the same cycle as rx_valid. Counters update in the same cycle.
- frame_start and samp_valid in the same cycle while in IDLE: frame_start is taken, and the strobe is not counted as a data bit.
- Back-to-back frames are legal: frame_start may arrive in the cycle rx_valid is high.
- Asserting rst_n low mid-frame aborts the frame immediately. No rx_valid is produced, and the counters clear.

## Structure
- Shared UART package: the state enum (IDLE/DATA/PARITY/STOP1/STOP2) and the parity-mode encoding (EVEN=0, ODD=1).
- One natural sub-module, uart_sat_counter (parameter CNT_WIDTH; ports inc, clr, count), instantiated twice.
- bit_cnt width is $clog2(DATA_WIDTH+1).

## Test plan
- DATA_WIDTH=8, no parity, one stop; bits of 0xA5 LSB-first, then stop=1 -> rx_valid one cycle later, rx_data=0xA5, par_err=0, stop_err=0, counters stay 0.
- Even parity, data 0x03, parity bit 0 -> par_err=0. Same data with parity bit 1 -> par_err=1, par_err_cnt=1.
- Odd parity, data 0x07, parity bit 0 -> par_err=0.
- two_stop=1, stop bits 1,0 -> completes after the second stop with stop_err=1. Stop bits 0,x -> completes after the first stop with stop_err=1, and the second strobe is treated as idle.
- 256 frames with a bad stop bit, CNT_WIDTH=8 -> stop_err_cnt saturates at 255. clr_cnt in the same cycle as an increment -> 0.
- rst_n low after 4 data bits -> busy=0 and all outputs 0 asynchronously. A following clean frame of 0x3C is received correctly.
